// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with shadow configuration and overlap control.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       din,
  input  logic                       din_valid,
  input  logic                       cfg_load,
  input  logic [MAX_LEN-1:0]         cfg_pattern,
  input  logic [$clog2(MAX_LEN):0]   cfg_len,
  input  logic                       cfg_overlap,
  output logic                       detect,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_MIN = LW'(2);

  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic               overlap;
  logic [MAX_LEN-1:0] hist;
  logic [LW-1:0]      fill;

  logic [MAX_LEN-1:0] hist_next;
  logic [LW-1:0]      fill_next;
  logic [MAX_LEN-1:0] mask;
  logic               enabled;
  logic               match;

  always_comb begin
    hist_next = {hist[MAX_LEN-2:0], din};
    fill_next = (fill == LEN_MAX) ? fill : fill + 1'b1;
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len);
    end
    enabled = (len >= LEN_MIN);
    match   = din_valid && enabled && (fill_next >= len) &&
              (((hist_next ^ pat) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pat     <= '0;
      len     <= '0;
      overlap <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      detect  <= 1'b0;
    end else if (cfg_load) begin
      pat     <= cfg_pattern;
      len     <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      overlap <= cfg_overlap;
      hist    <= '0;
      fill    <= '0;
      detect  <= 1'b0;
    end else if (din_valid) begin
      hist <= hist_next;
      // Non-overlap restarts the fill count so no matched bit is reused.
      fill <= (match && !overlap) ? '0 : fill_next;
      if (enabled) detect <= match;
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn || cfg_load) begin
      cnt <= '0;
    end else if (match && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomized and directed self-checking bench for seq_detector_prog.
// Expected values come from a queue-based model of the detection rules.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               detect;
  logic [CNT_W-1:0]   match_cnt;

  int passed = 0;
  int total  = 0;

  // reference model state
  bit               mq[$];
  logic [MAX_LEN-1:0] m_pat = '0;
  int               m_len = 0;
  bit               m_ov  = 1'b0;
  bit               m_det = 1'b0;
  int               m_cnt = 0;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .detect(detect), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clk();
    bit hit;
    if (!rstn) begin
      mq.delete(); m_pat = '0; m_len = 0; m_ov = 0; m_det = 0; m_cnt = 0;
    end else if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      m_ov  = cfg_overlap;
      mq.delete(); m_det = 0; m_cnt = 0;
    end else if (din_valid) begin
      mq.push_back(din);
      if (m_len >= 2) begin
        hit = (mq.size() >= m_len);
        if (hit) begin
          for (int k = 0; k < m_len; k++)
            if (mq[mq.size()-1-k] != m_pat[k]) hit = 0;
        end
        m_det = hit;
        if (hit && CNT_EN && m_cnt < CNT_MAX) m_cnt++;
        if (hit && !m_ov) mq.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic drive(input logic b, input logic v);
    din = b; din_valid = v; cfg_load = 0;
    tick();
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input int l, input logic ov,
                      input logic v, input logic b);
    cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = ov;
    din = b; din_valid = v; cfg_load = 1;
    tick();
    cfg_load = 0; din_valid = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    // cfg_load during reset must not take effect
    cfg_load = 1; cfg_pattern = 8'h03; cfg_len = LW'(2); cfg_overlap = 1;
    din = 1; din_valid = 1;
    tick(); tick();
    total++;
    if (detect !== 1'b0 || match_cnt !== '0)
      $display("FAIL reset_state: detect=%0b cnt=%0d expected 0/0", detect, match_cnt);
    else passed++;
    cfg_load = 0; rstn = 1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
    total++;
    if (detect !== 1'b0 || match_cnt !== '0)
      $display("FAIL reset_len0: detect=%0b cnt=%0d expected 0/0", detect, match_cnt);
    else passed++;
  endtask

  task automatic run_1011(input logic ov, input logic [6:0] exp_det, input int exp_cnt,
                          input string name);
    logic [6:0] stream;
    stream = 7'b1011011;
    load(8'b1011, 4, ov, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(stream[6-i], 1'b1);
      total++;
      if (detect !== exp_det[6-i] || detect !== m_det)
        $display("FAIL %s_det bit%0d: detect=%0b expected %0b", name, i + 1, detect, exp_det[6-i]);
      else passed++;
    end
    total++;
    if (int'(match_cnt) !== exp_cnt)
      $display("FAIL %s_cnt: cnt=%0d expected %0d", name, match_cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_overlap();
    run_1011(1'b1, 7'b0001001, CNT_EN ? 2 : 0, "overlap");
  endtask

  task automatic test_non_overlap();
    run_1011(1'b0, 7'b0001000, CNT_EN ? 1 : 0, "non_overlap");
  endtask

  task automatic test_valid_gap();
    load(8'b101, 3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 1'b0);
      total++;
      if (detect !== 1'b0)
        $display("FAIL gap_hold cyc%0d: detect=%0b expected 0", i, detect);
      else passed++;
    end
    drive(1'b1, 1'b1);
    total++;
    if (detect !== 1'b1)
      $display("FAIL gap_final: detect=%0b expected 1", detect);
    else passed++;
    drive(1'b0, 1'b0);
    total++;
    if (detect !== 1'b1)
      $display("FAIL gap_hold_after: detect=%0b expected 1", detect);
    else passed++;
  endtask

  task automatic test_reconfig();
    load(8'b1011, 4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1); drive(1'b0, 1'b1); drive(1'b1, 1'b1);
    // load a new pattern while a valid '1' is presented: that bit is dropped
    load(8'b0110, 4, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1);
    total++;
    if (detect !== 1'b0 || match_cnt !== '0)
      $display("FAIL reconfig_drop: detect=%0b cnt=%0d expected 0/0", detect, match_cnt);
    else passed++;
    drive(1'b0, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
    total++;
    if (detect !== 1'b0)
      $display("FAIL reconfig_partial: detect=%0b expected 0", detect);
    else passed++;
    drive(1'b0, 1'b1);
    total++;
    if (detect !== 1'b1)
      $display("FAIL reconfig_new: detect=%0b expected 1", detect);
    else passed++;
  endtask

  task automatic test_limits();
    logic [7:0] p8;
    load(8'b11, 2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1);
    total++;
    if (int'(match_cnt) !== (CNT_EN ? 3 : 0))
      $display("FAIL sat_cnt: cnt=%0d expected %0d", match_cnt, CNT_EN ? 3 : 0);
    else passed++;
    p8 = 8'b10110011;
    load(p8, MAX_LEN + 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) begin
      drive(p8[MAX_LEN-1-i], 1'b1);
      total++;
      if (detect !== (i == MAX_LEN - 1))
        $display("FAIL len_clamp bit%0d: detect=%0b expected %0b", i, detect, i == MAX_LEN - 1);
      else passed++;
    end
    load(8'h00, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
    total++;
    if (detect !== 1'b0 || match_cnt !== '0)
      $display("FAIL len0: detect=%0b cnt=%0d expected 0/0", detect, match_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    load(8'b1011, 4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1); drive(1'b0, 1'b1); drive(1'b1, 1'b1);
    rstn = 0; din = 1; din_valid = 1;
    tick();
    rstn = 1;
    total++;
    if (detect !== 1'b0 || match_cnt !== '0)
      $display("FAIL rst_mid: detect=%0b cnt=%0d expected 0/0", detect, match_cnt);
    else passed++;
    drive(1'b1, 1'b1); drive(1'b0, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
    total++;
    if (detect !== 1'b0)
      $display("FAIL rst_disabled: detect=%0b expected 0", detect);
    else passed++;
    load(8'b10, 2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1); drive(1'b0, 1'b1);
    total++;
    if (detect !== 1'b1)
      $display("FAIL rst_reload: detect=%0b expected 1", detect);
    else passed++;
  endtask

  task automatic test_random();
    int r;
    int errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rstn = 0; din = 1'($urandom); din_valid = 1'($urandom);
        tick();
        rstn = 1;
      end else if (r < 8) begin
        load(MAX_LEN'($urandom),
             ($urandom_range(0, 3) != 0) ? $urandom_range(2, 4) : $urandom_range(0, MAX_LEN + 3),
             1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        drive(1'($urandom), $urandom_range(0, 3) != 0);
      end
      total++;
      if (detect !== m_det || int'(match_cnt) !== m_cnt) begin
        if (errs < 10)
          $display("FAIL random cyc%0d: detect=%0b cnt=%0d expected %0b/%0d",
                   i, detect, match_cnt, m_det, m_cnt);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_valid_gap();
    test_reconfig();
    test_limits();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port din, input, 1 bit: serial data bit.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din is accepted on a rising edge only when this is high.
REQ-007 The block SHALL have port cfg_load, input, 1 bit: latch the configuration inputs and clear detection history.
REQ-008 The block SHALL have port cfg_pattern, input, MAX_LEN bits: pattern; cfg_pattern[len-1] is the first bit received, cfg_pattern[0] the last.
REQ-009 The block SHALL have port cfg_len, input, $clog2(MAX_LEN)+1 bits: pattern length.
REQ-010 The block SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-011 The block SHALL have port detect, output, 1 bit: registered Moore match flag.
REQ-012 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-013 The block SHALL sample cfg_pattern, cfg_len and cfg_overlap into internal shadow registers only on a cycle with cfg_load=1; detection SHALL use only the shadow values.
REQ-014 The block SHALL clamp a loaded cfg_len greater than MAX_LEN to MAX_LEN, and a loaded length of 0 or 1 SHALL disable detection (detect and match_cnt never change).
REQ-015 The block SHALL keep a history shift register of accepted bits (newest in bit 0) and a fill counter, saturating at MAX_LEN, of bits accepted since the last clear.
REQ-016 On an accepted bit, the block SHALL declare a match when fill (including the new bit) >= len and the newest len history bits, including the new bit, equal cfg_pattern[len-1:0].
REQ-017 detect SHALL update only on accepted bits: 1 in the cycle after an accepted bit that produces a match, 0 after an accepted bit that does not; it SHALL hold its value while din_valid=0.
REQ-018 In overlap mode, the history and fill counter SHALL be kept after a match.
REQ-019 In non-overlap mode, the fill counter SHALL be set to 0 after a match, so no later match can reuse any bit of it.
REQ-020 cfg_load SHALL clear the history, fill counter, detect and match_cnt on the same edge; if din_valid=1 in the same cycle, that bit SHALL be discarded (cfg_load wins).
REQ-021 Latency SHALL be 1 cycle from the edge that accepts the completing bit to detect=1.
REQ-022 The block SHALL hold no other state beyond the shadow configuration, history, fill counter, detect and match_cnt.

Reset
REQ-023 While rstn=0 at a rising edge: detect=0, match_cnt=0, history=0, fill=0; shadow pattern=0, shadow len=0 (detection disabled), shadow overlap=0.
REQ-024 Reset SHALL take priority over cfg_load and din_valid, and reset mid-pattern SHALL discard the partial sequence.

Configuration
REQ-025 With macro SEQ_DET_MATCH_CNT_EN defined, match_cnt SHALL increment by 1 on every match and saturate at 2^CNT_W-1, with no wrap.
REQ-026 Without SEQ_DET_MATCH_CNT_EN, match_cnt SHALL be tied to 0, no counter flops SHALL be built, and the port SHALL remain present.

Verification
REQ-027 Overlap test: pattern 1011, len 4, overlap=1; valid stream 1,0,1,1,0,1,1 -> detect=1 after the 4th and 7th bits only; match_cnt=2.
REQ-028 Non-overlap test: same stream with overlap=0 -> detect=1 after the 4th bit only; match_cnt=1.
REQ-029 Valid gap test: pattern 101, len 3; bits 1,0 then din_valid=0 for 5 cycles with din toggling, then bit 1 -> detect stays 0 through the gap, then 1 one cycle after the final accepted bit.
REQ-030 Reconfiguration test: cfg_load with a new pattern after 3 bits of a 4-bit match, with din_valid=1 in the same cycle -> that bit is dropped; the old partial match is never completed; detect=0 and match_cnt=0.
REQ-031 Saturation/limits test (macro defined, CNT_W=2): 5 matches -> match_cnt=3; cfg_len=MAX_LEN+3 behaves as len=MAX_LEN; cfg_len=0 -> no detect on any stream.
REQ-032 Reset test: rstn=0 for 1 cycle mid-pattern -> detect=0 and match_cnt=0, and no detection occurs until cfg_load sets a len of 2 or more.
